// File: rtl/read_pkg.sv
// Shared defaults and types for the read-port mux tree.
package read_pkg;

    localparam int unsigned WIDTH  = 20;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;

    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Heap-indexed tree node n (root = 1) sits on the level steered by R[aw - clog2(n+1)].
    function automatic int unsigned tree_level(input int unsigned n, input int unsigned aw);
        return aw - 32'($clog2(n + 1));
    endfunction

endpackage

// File: rtl/read_mux2.sv
// WIDTH-wide 2:1 mux, one node of the read select tree.
module read_mux2 #(
    parameter int unsigned WIDTH = 20
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/read.sv
// Read port: DEPTH:1 word select built as a binary 2:1 mux tree, R[k] steering level k.
// Define READ_REG_EN to register the output (one cycle of latency, async clear on rst).
module read
    import read_pkg::*;
#(
    parameter int unsigned WIDTH  = read_pkg::WIDTH,
    parameter int unsigned DEPTH  = read_pkg::DEPTH,
    parameter int unsigned ADDR_W = read_pkg::ADDR_W
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] a,
    input  logic [ADDR_W-1:0]           R,
    output logic [WIDTH-1:0]            out,
    input  logic                        clk,
    input  logic                        rst
);

    // Heap layout: node[n-1] holds tree node n; leaves n = DEPTH..2*DEPTH-1 carry a[].
    logic [WIDTH-1:0] node [2*DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_leaf
        assign node[DEPTH+i-1] = a[i];
    end

    for (genvar n = 1; n < DEPTH; n++) begin : g_tree
        localparam int unsigned K = tree_level(n, ADDR_W);
        read_mux2 #(.WIDTH(WIDTH)) u_mux (
            .d0 (node[2*n-1]),
            .d1 (node[2*n]),
            .s  (R[K]),
            .y  (node[n-1])
        );
    end

`ifdef READ_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= node[0];
        end
    end
`else
    // Clock and reset only matter when the output register is built.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out            = node[0];
`endif

endmodule

// File: tb/tb_read.sv
// Self-checking bench for read; exercises the registered mode when READ_REG_EN is defined.
module tb_read;

    localparam int unsigned W  = 20;
    localparam int unsigned D  = 64;
    localparam int unsigned AW = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [D-1:0][W-1:0]  a;
    logic [AW-1:0]        R;
    logic [W-1:0]         out;

    logic [W-1:0] mem [D];
    int checks = 0;
    int errors = 0;
    bit clk_en = 1'b0;

    read #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .a   (a),
        .R   (R),
        .out (out),
        .clk (clk),
        .rst (rst)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic push_mem();
        for (int i = 0; i < int'(D); i++) a[i] = mem[i];
    endtask

    task automatic check(input string name, input logic [W-1:0] exp);
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL %s R=%0d got %h want %h", name, R, out, exp);
        end
    endtask

    task automatic load_index();
        for (int i = 0; i < int'(D); i++) mem[i] = W'(i);
        push_mem();
    endtask

    task automatic load_walk();
        for (int i = 0; i < int'(D); i++) mem[i] = W'(1) << (i % int'(W));
        push_mem();
    endtask

`ifndef READ_REG_EN
    // Combinational mode: out must track mem[R] with no clock at all.
    initial begin
        R = '0;
        load_index();
        #1 check("r0", 20'h00000);
        R = 6'd1;          #1 check("r1", 20'h00001);
        R = 6'b100000;     #1 check("r32", 20'h00020);
        R = 6'b110000;     #1 check("r48", 20'h00030);
        R = 6'b111111;     #1 check("r63_top", 20'h0003F);
        mem[63] = 20'hFFFFF; push_mem();
        #1 check("a63_update", 20'hFFFFF);
        rst = 1'b1;        #1 check("rst_no_effect", 20'hFFFFF);
        rst = 1'b0;

        for (int k = 0; k < 200; k++) begin
            mem[$urandom_range(0, D-1)] = W'($urandom);
            R = AW'($urandom_range(0, D-1));
            push_mem();
            #1 check("rand", mem[R]);
        end

        load_walk();
        for (int i = 0; i < int'(D); i++) begin
            R = AW'(i);
            #1 check("walk", W'(1) << (i % int'(W)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
`else
    // Registered mode: out at each edge reflects mem[R] as it stood at that edge.
    task automatic edge_check(input string name);
        logic [W-1:0] exp;
        exp = rst ? '0 : mem[R];
        @(posedge clk);
        #1 check(name, exp);
    endtask

    initial begin
        R = 6'd5;
        load_index();
        rst = 1'b1;
        #1 check("rst_async", 20'h00000);
        clk_en = 1'b1;
        @(posedge clk); #1 check("rst_hold", 20'h00000);
        #2 rst = 1'b0;
        #1 check("pre_first_edge", 20'h00000);
        @(posedge clk); #1 check("first_capture", 20'h00005);

        R = 6'd10; @(posedge clk); #1 check("step10", 20'h0000A);
        R = 6'd11; @(posedge clk); #1 check("step11", 20'h0000B);
        R = 6'd12;
        mem[11] = 20'h12345; push_mem();
        #1 check("hold_between_edges", 20'h0000B);
        @(posedge clk); #1 check("step12", 20'h0000C);

        R = 6'd20;
        #1 rst = 1'b1;
        #1 check("rst_midstream", 20'h00000);
        @(posedge clk); #1 check("rst_over_edge", 20'h00000);
        rst = 1'b0;
        R = 6'd33;
        #1 check("no_stale", 20'h00000);
        edge_check("after_release");

        for (int k = 0; k < 200; k++) begin
            mem[$urandom_range(0, D-1)] = W'($urandom);
            R = AW'($urandom_range(0, D-1));
            push_mem();
            edge_check("rand");
        end

        load_walk();
        for (int i = 0; i < int'(D); i++) begin
            R = AW'(i);
            edge_check("walk");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
`endif

endmodule

// File: doc/read.md
READ -- requirements
Module: read

Interface
REQ-001 Parameter WIDTH, default 20, SHALL set the bits per memory word.
REQ-002 Parameter DEPTH, default 64, SHALL set the number of words; it SHALL be a power of two.
REQ-003 Parameter ADDR_W, default 6, SHALL equal log2(DEPTH).
REQ-004 clk  input  1  SHALL be the single clock; all registered logic is rising-edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 a  input  [DEPTH-1:0][WIDTH-1:0] packed  SHALL be the memory bank contents, word i at a[i].
REQ-007 R  input  ADDR_W  SHALL be the read address.
REQ-008 out  output  WIDTH  SHALL be the read data.
REQ-009 Ports SHALL be declared in the order a, R, out, clk, rst, so a positional three-port instantiation (a, R, out) binds correctly with clk/rst left unconnected.

Function
REQ-010 Without READ_REG_EN, out SHALL equal a[R] combinationally: zero latency, no clock required, and it SHALL update on any change of a or R.
REQ-011 All DEPTH addresses SHALL be valid; there is no out-of-range case, and R = DEPTH-1 SHALL return the top word.
REQ-012 out SHALL be the exact WIDTH-bit word, with no sign extension, truncation or bit reordering.
REQ-013 The select SHALL be built as a log2(DEPTH)-level binary 2:1 mux tree; level k SHALL be steered by R[k], LSB first.
REQ-014 With READ_REG_EN, out SHALL be registered: out at clock edge n+1 equals a[R] sampled at edge n, giving one cycle of latency.
REQ-015 With READ_REG_EN, changes in a or R between edges SHALL NOT affect out until the next rising edge.
REQ-016 If X or Z appears on R, out SHALL NOT be forced to a defined value; X propagation is acceptable.

Reset
REQ-017 Without READ_REG_EN, rst and clk SHALL have no effect.
REQ-018 With READ_REG_EN, asserting rst SHALL clear out to 0 immediately, independent of clk.
REQ-019 With READ_REG_EN, out SHALL hold 0 while rst is high, and the first capture SHALL occur on the first rising edge after rst deasserts.
REQ-020 A reset arriving mid-stream SHALL discard any pending captured word; no stale data SHALL appear after release.

Configuration
REQ-021 Macro READ_REG_EN SHALL, when defined, insert the output register described in REQ-014 and REQ-018 to REQ-020.
REQ-022 When READ_REG_EN is undefined, the output register SHALL be absent and the block SHALL be purely combinational (REQ-010).

Structure
REQ-023 Shared package read_pkg SHALL hold:
- WIDTH, DEPTH and ADDR_W default constants;
- typedef word_t (logic [WIDTH-1:0]);
- typedef addr_t (logic [ADDR_W-1:0]).
REQ-024 A single sub-module, read_mux2 (a WIDTH-wide 2:1 mux), SHALL be instantiated across the tree levels via generate loops.
REQ-025 The top level SHALL contain only the tree generate, the optional output register and the port wiring.

Verification (bench loads a[i] = i for i = 0..63)
REQ-026 Combinational mode: R = 0 -> out = 20'h00000; R = 1 -> out = 20'h00001, with no clock toggled.
REQ-027 Combinational mode: R = 6'b100000 -> out = 20'h00020; R = 6'b110000 -> out = 20'h00030.
REQ-028 Combinational mode: R = 6'b111111 (top boundary) -> out = 20'h0003F; then a[63] changed to 20'hFFFFF -> out = 20'hFFFFF in the same timestep.
REQ-029 READ_REG_EN: rst = 1 -> out = 0 without a clock edge; release rst with R = 5 -> out = 20'h00005 after the first rising edge, and out = 0 before that edge.
REQ-030 READ_REG_EN: R steps 10, 11, 12 on successive edges -> out shows 10, 11, 12 each one cycle later; rst pulsed between edges -> out = 0 immediately.
REQ-031 Walking one: a[i] = 1 << (i mod 20), R swept 0..63 -> every out matches, covering each mux-tree select bit in both states.
